// File: rtl/slow_vram_bridge.sv
`default_nettype none
// slow_vram_bridge -- SRAM-style slow VRAM strobes to a 32-bit req/ack memory port,
// with a one-dword read cache and a one-deep write buffer.                 rev 1.0
module slow_vram_bridge (
  input  logic        CLK,
  input  logic        RESETP,
  input  logic [14:0] SVRAM_ADDR,
  input  logic [15:0] SVRAM_DATA_OUT,
  input  logic        BOE,
  input  logic        BWE,
  output logic [31:0] SVRAM_DATA_IN,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [13:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic [1:0]  MEM_WMASK,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA,
  output logic        WR_OVERFLOW
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WR = 2'd1, ST_RD = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [14:0] addr_s1_q;
  logic [15:0] data_s1_q;
  logic        boe_s1_q, bwe_s1_q, bwe_s2_q;
  logic        valid_q, valid_d;
  logic [13:0] tag_q, tag_d;
  logic [31:0] cdata_q, cdata_d;
  logic        wb_full_q, wb_full_d;
  logic [14:0] wb_addr_q, wb_addr_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic        rd_stale_q, rd_stale_d;
  logic [31:0] rdout_q, rdout_d;
  logic        req_q, req_d, we_q, we_d;
  logic [13:0] maddr_q, maddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  wmask_q, wmask_d;
  logic        ovf_q, ovf_d;

  logic wr_evt, rd_dem, hit, fill, same_fill, issue_wr, buf_free;

  function automatic logic [31:0] order_words(input logic odd, input logic [31:0] d);
    return odd ? {d[15:0], d[31:16]} : d;
  endfunction

  always_ff @(posedge CLK or negedge RESETP) begin
    if (!RESETP) begin
      addr_s1_q <= '0;
      data_s1_q <= '0;
      boe_s1_q  <= 1'b1;
      bwe_s1_q  <= 1'b1;
      bwe_s2_q  <= 1'b1;
    end else begin
      addr_s1_q <= SVRAM_ADDR;
      data_s1_q <= SVRAM_DATA_OUT;
      boe_s1_q  <= BOE;
      bwe_s1_q  <= BWE;
      bwe_s2_q  <= bwe_s1_q;
    end
  end

  always_comb begin
    wr_evt    = bwe_s2_q & ~bwe_s1_q;
    rd_dem    = ~boe_s1_q & bwe_s1_q;
    hit       = valid_q && (tag_q == addr_s1_q[14:1]);
    fill      = (state_q == ST_RD) && MEM_ACK;
    same_fill = (addr_s1_q[14:1] == maddr_q);
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    cdata_d    = cdata_q;
    wb_full_d  = wb_full_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    rd_stale_d = rd_stale_q;
    rdout_d    = rdout_q;
    req_d      = req_q;
    we_d       = we_q;
    maddr_d    = maddr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    ovf_d      = ovf_q;
    issue_wr   = 1'b0;

    if (rd_dem && hit)
      rdout_d = order_words(addr_s1_q[0], cdata_q);

    case (state_q)
      ST_IDLE: begin
        if (wb_full_q) begin
          // The buffered write moves into the port registers, freeing the buffer
          // for the next CPU write while this one is in flight.
          issue_wr  = 1'b1;
          state_d   = ST_WR;
          req_d     = 1'b1;
          we_d      = 1'b1;
          maddr_d   = wb_addr_q[14:1];
          wdata_d   = {wb_data_q, wb_data_q};
          wmask_d   = wb_addr_q[0] ? 2'b10 : 2'b01;
          wb_full_d = 1'b0;
        end else if (rd_dem && !hit) begin
          state_d    = ST_RD;
          req_d      = 1'b1;
          we_d       = 1'b0;
          maddr_d    = addr_s1_q[14:1];
          wmask_d    = 2'b00;
          rd_stale_d = 1'b0;
        end
      end
      ST_WR: begin
        if (MEM_ACK) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
        end
      end
      ST_RD: begin
        if (wr_evt && same_fill)
          rd_stale_d = 1'b1;
        if (MEM_ACK) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          tag_d   = maddr_q;
          cdata_d = MEM_RDATA;
          valid_d = !(rd_stale_q || (wr_evt && same_fill));
          if (rd_dem && same_fill && !rd_stale_q)
            rdout_d = order_words(addr_s1_q[0], MEM_RDATA);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    buf_free = !wb_full_q || issue_wr;
    if (wr_evt) begin
      if (buf_free) begin
        wb_full_d = 1'b1;
        wb_addr_d = addr_s1_q;
        wb_data_d = data_s1_q;
        // Dropped writes never reach memory, so they must not reach the cache either.
        if (!fill && hit) begin
          if (addr_s1_q[0]) cdata_d[31:16] = data_s1_q;
          else              cdata_d[15:0]  = data_s1_q;
        end
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETP) begin
    if (!RESETP) begin
      state_q    <= ST_IDLE;
      valid_q    <= 1'b0;
      tag_q      <= '0;
      cdata_q    <= '0;
      wb_full_q  <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      rd_stale_q <= 1'b0;
      rdout_q    <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      maddr_q    <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      cdata_q    <= cdata_d;
      wb_full_q  <= wb_full_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      rd_stale_q <= rd_stale_d;
      rdout_q    <= rdout_d;
      req_q      <= req_d;
      we_q       <= we_d;
      maddr_q    <= maddr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      ovf_q      <= ovf_d;
    end
  end

  assign SVRAM_DATA_IN = rdout_q;
  assign MEM_REQ       = req_q;
  assign MEM_WE        = we_q;
  assign MEM_ADDR      = maddr_q;
  assign MEM_WDATA     = wdata_q;
  assign MEM_WMASK     = wmask_q;
  assign WR_OVERFLOW   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_slow_vram_bridge.sv
`default_nettype none
// tb_slow_vram_bridge -- directed and randomized checks of slow_vram_bridge against a
// word-level golden VRAM image and a behavioural SDRAM-side responder.   rev 1.0
module tb_slow_vram_bridge;

  logic        CLK = 1'b0;
  logic        RESETP = 1'b0;
  logic [14:0] SVRAM_ADDR = '0;
  logic [15:0] SVRAM_DATA_OUT = '0;
  logic        BOE = 1'b1;
  logic        BWE = 1'b1;
  logic [31:0] SVRAM_DATA_IN;
  logic        MEM_REQ, MEM_WE, WR_OVERFLOW;
  logic [13:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [1:0]  MEM_WMASK;
  logic        MEM_ACK = 1'b0;
  logic [31:0] MEM_RDATA = '0;

  slow_vram_bridge dut (
    .CLK(CLK), .RESETP(RESETP), .SVRAM_ADDR(SVRAM_ADDR), .SVRAM_DATA_OUT(SVRAM_DATA_OUT),
    .BOE(BOE), .BWE(BWE), .SVRAM_DATA_IN(SVRAM_DATA_IN), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_WMASK(MEM_WMASK), .MEM_ACK(MEM_ACK),
    .MEM_RDATA(MEM_RDATA), .WR_OVERFLOW(WR_OVERFLOW)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {logic [13:0] a; logic [31:0] d; logic [1:0] m;} wr_t;

  int          n_vec = 0, n_err = 0;
  logic [31:0] mem  [0:16383];
  logic [15:0] gold [0:32767];
  wr_t         wq[$];
  wr_t         wlog[$];
  logic [14:0] txlog[$];
  int          ack_delay = 0;
  bit          ack_hold = 1'b0;
  int          n_rd = 0, n_wr = 0, n_req = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // SDRAM-side responder: ACK after ack_delay idle cycles, one-cycle pulse.
  initial begin
    int  wait_cnt;
    bit  req_prev;
    wr_t o;
    wait_cnt = 0;
    req_prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (MEM_REQ && !req_prev) n_req++;
      req_prev = MEM_REQ;
      if (MEM_ACK) MEM_ACK = 1'b0;
      else if (RESETP && MEM_REQ && !ack_hold) begin
        if (wait_cnt >= ack_delay) begin
          wait_cnt = 0;
          MEM_ACK  = 1'b1;
          txlog.push_back({MEM_WE, MEM_ADDR});
          if (MEM_WE) begin
            n_wr++;
            o.a = MEM_ADDR; o.d = MEM_WDATA; o.m = MEM_WMASK;
            wlog.push_back(o);
            if (MEM_WMASK[0]) mem[MEM_ADDR][15:0]  = MEM_WDATA[15:0];
            if (MEM_WMASK[1]) mem[MEM_ADDR][31:16] = MEM_WDATA[31:16];
          end else begin
            n_rd++;
            MEM_RDATA = mem[MEM_ADDR];
          end
        end else wait_cnt++;
      end else wait_cnt = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drain_writes();
    wr_t g, e;
    while (wlog.size() > 0) begin
      g = wlog.pop_front();
      check("wr_expected", 32'(wq.size() > 0), 1);
      if (wq.size() > 0) begin
        e = wq.pop_front();
        check("wr_addr", 32'(g.a), 32'(e.a));
        check("wr_data", g.d, e.d);
        check("wr_mask", 32'(g.m), 32'(e.m));
      end
    end
  endtask

  task automatic wait_idle();
    int idle = 0;
    for (int i = 0; i < 400 && idle < 4; i++) begin
      @(negedge CLK);
      if (MEM_REQ) idle = 0; else idle++;
    end
    check("idle_reached", 32'(idle >= 4), 1);
    drain_writes();
  endtask

  task automatic wait_req();
    int n = 0;
    while (!MEM_REQ && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("req_seen", 32'(MEM_REQ), 1);
  endtask

  task automatic do_write(input logic [14:0] a, input logic [15:0] d, input bit accepted);
    wr_t e;
    if (accepted) begin
      gold[a] = d;
      e.a = a[14:1]; e.d = {d, d}; e.m = a[0] ? 2'b10 : 2'b01;
      wq.push_back(e);
    end
    SVRAM_ADDR = a; SVRAM_DATA_OUT = d; BOE = 1'b1; BWE = 1'b0;
    tick(2);
    BWE = 1'b1;
    tick(2);
  endtask

  task automatic do_read(input logic [14:0] a);
    SVRAM_ADDR = a; BWE = 1'b1; BOE = 1'b0;
    wait_idle();
    check("rd_data", SVRAM_DATA_IN, {gold[a ^ 15'd1], gold[a]});
    BOE = 1'b1;
  endtask

  initial begin
    int          r0, q0, w0, t0;
    logic [14:0] ra;
    for (int i = 0; i < 16384; i++) begin
      mem[i] = $urandom;
      gold[2*i]   = mem[i][15:0];
      gold[2*i+1] = mem[i][31:16];
    end
    tick(3);
    check("rst_data_in", SVRAM_DATA_IN, 0);
    check("rst_req", 32'(MEM_REQ), 0);
    check("rst_we", 32'(MEM_WE), 0);
    check("rst_addr", 32'(MEM_ADDR), 0);
    check("rst_wdata", MEM_WDATA, 0);
    check("rst_wmask", 32'(MEM_WMASK), 0);
    check("rst_ovf", 32'(WR_OVERFLOW), 0);
    RESETP = 1'b1;
    tick(2);

    // Cold read miss
    mem[14'h091A] = 32'hBEEFCAFE; gold[15'h1234] = 16'hCAFE; gold[15'h1235] = 16'hBEEF;
    ack_delay = 5; r0 = n_rd;
    do_read(15'h1234);
    check("cold_nrd", 32'(n_rd - r0), 1);
    check("cold_addr", 32'(txlog[$]), {17'd0, 1'b0, 14'h091A});
    check("cold_data", SVRAM_DATA_IN, 32'hBEEFCAFE);

    // Odd-address hit: output swaps two clocks after the change, no request
    q0 = n_req;
    SVRAM_ADDR = 15'h1235; BOE = 1'b0;
    @(negedge CLK); check("swap_lat1", SVRAM_DATA_IN, 32'hBEEFCAFE);
    @(negedge CLK); check("swap_lat2", SVRAM_DATA_IN, 32'hCAFEBEEF);
    repeat (6) @(negedge CLK);
    check("swap_noreq", 32'(n_req), 32'(q0));
    BOE = 1'b1;

    // Write-through on the cached dword
    do_write(15'h1235, 16'h5555, 1'b1);
    wait_idle();
    check("wt_tx", 32'(txlog[$]), {17'd0, 1'b1, 14'h091A});
    q0 = n_req;
    do_read(15'h1234);
    check("wt_hit_data", SVRAM_DATA_IN, 32'h5555CAFE);
    check("wt_hit_noreq", 32'(n_req), 32'(q0));

    // Write to the dword being fetched: RD, WR, then a re-fetch RD
    ack_delay = 8; t0 = txlog.size();
    SVRAM_ADDR = 15'h0100; BWE = 1'b1; BOE = 1'b0;
    wait_req();
    do_write(15'h0101, 16'hA5A5, 1'b1);
    do_read(15'h0100);
    check("pend_ntx", 32'(txlog.size() - t0), 3);
    check("pend_tx0", 32'(txlog[t0]),   {17'd0, 1'b0, 14'h0080});
    check("pend_tx1", 32'(txlog[t0+1]), {17'd0, 1'b1, 14'h0080});
    check("pend_tx2", 32'(txlog[t0+2]), {17'd0, 1'b0, 14'h0080});

    // Address extremes
    ack_delay = 1;
    do_write(15'h7FFF, 16'h1357, 1'b1);
    wait_idle();
    check("top_tx", 32'(txlog[$]), {17'd0, 1'b1, 14'h3FFF});
    do_write(15'h0000, 16'h2468, 1'b1);
    wait_idle();
    check("bot_tx", 32'(txlog[$]), {17'd0, 1'b1, 14'h0000});
    do_read(15'h7FFF);
    do_read(15'h0000);

    // Overflow: one in flight, one buffered, one dropped
    ack_hold = 1'b1; ack_delay = 0; w0 = n_wr;
    do_write(15'h0200, 16'h1111, 1'b1);
    do_write(15'h0202, 16'h2222, 1'b1);
    check("ovf_clear", 32'(WR_OVERFLOW), 0);
    do_write(15'h0204, 16'h3333, 1'b0);
    tick(1);
    check("ovf_set", 32'(WR_OVERFLOW), 1);
    ack_hold = 1'b0;
    wait_idle();
    check("ovf_nwr", 32'(n_wr - w0), 2);
    check("ovf_sticky", 32'(WR_OVERFLOW), 1);
    check("ovf_wq_empty", 32'(wq.size()), 0);
    do_read(15'h0204);
    do_read(15'h0202);

    // Reset during a read
    do_read(15'h0300);
    ack_hold = 1'b1;
    SVRAM_ADDR = 15'h0310; BOE = 1'b0;
    wait_req();
    #2 RESETP = 1'b0;
    #1 check("rst_req_async", 32'(MEM_REQ), 0);
    check("rst_ovf_clr", 32'(WR_OVERFLOW), 0);
    BOE = 1'b1;
    tick(2);
    ack_hold = 1'b0;
    RESETP = 1'b1;
    tick(2);
    r0 = n_rd;
    do_read(15'h0300);
    check("post_rst_miss", 32'(n_rd - r0), 1);

    // Randomized traffic over a few dwords so hits, misses and write-through interleave
    for (int i = 0; i < 200; i++) begin
      ra = 15'h0400 + 15'($urandom_range(0, 15));
      ack_delay = $urandom_range(0, 4);
      if ($urandom_range(0, 2) == 0) begin
        do_write(ra, 16'($urandom), 1'b1);
        wait_idle();
      end else begin
        do_read(ra);
      end
    end

    wait_idle();
    check("final_wq_empty", 32'(wq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
